tile_egress_arbiter: RTL

Packet-level round-robin arbiter that shares a tile's single local NoC injection port (the switch local-in AXI-Stream) among N_REQ on-tile stream sources, such as the accelerator output and the control-path message source. A grant is held for the whole packet, from first beat to TLAST, so packets never interleave on the switch. The block sits between the tile's stream sources and the switch local-in port, in the clk_line domain. It also reports packet statistics and a mid-packet stall error.

---
 rtl/tile_egress_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tile_egress_arbiter.sv
// Packet-level round-robin arbiter sharing the tile's NoC local-in stream port.
// Grant is held from first beat to TLAST; also counts packets and flags mid-packet stalls.
module tile_egress_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned BW          = 32,
  parameter int unsigned STALL_LIMIT = 256,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned BWB        = BW / 8,
  localparam int unsigned GW         = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_line,
  input  logic                   clk_line_rst_high,
  input  logic [N_REQ-1:0]       src_TVALID,
  input  logic [N_REQ*BW-1:0]    src_TDATA,
  input  logic [N_REQ*BWB-1:0]   src_TKEEP,
  input  logic [N_REQ-1:0]       src_TLAST,
  output logic [N_REQ-1:0]       src_TREADY,
  output logic                   m_TVALID,
  output logic [BW-1:0]          m_TDATA,
  output logic [BWB-1:0]         m_TKEEP,
  output logic                   m_TLAST,
  input  logic                   m_TREADY,
  input  logic [N_REQ-1:0]       src_enable,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic [CNT_W-1:0]       pkt_count,
  output logic                   stall_err
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           r_state;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_rr_ptr;
  logic             r_busy;
  logic [CNT_W-1:0] r_pkt_count;
  logic [SW-1:0]    r_stall_cnt;
  logic             r_stall_err;

  logic [N_REQ-1:0] w_eligible;
  logic [GW-1:0]    w_winner;
  logic             w_any;
  logic             w_locked;
  logic             w_vld;
  logic             w_last;
  logic [BW-1:0]    w_data;
  logic [BWB-1:0]   w_keep;
  logic             w_done;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int step);
    return GW'((int'(base) + step) % int'(N_REQ));
  endfunction

  // Round-robin search starting just after the last served source
  always_comb begin
    w_eligible = src_TVALID & src_enable;
    w_winner   = '0;
    w_any      = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      if (!w_any && w_eligible[wrap_idx(r_rr_ptr, k)]) begin
        w_winner = wrap_idx(r_rr_ptr, k);
        w_any    = 1'b1;
      end
    end
  end

  // Select the granted source's stream signals
  always_comb begin
    w_vld  = 1'b0;
    w_last = 1'b0;
    w_data = '0;
    w_keep = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_grant == GW'(i)) begin
        w_vld  = src_TVALID[i];
        w_last = src_TLAST[i];
        w_data = src_TDATA[i*BW +: BW];
        w_keep = src_TKEEP[i*BWB +: BWB];
      end
    end
  end

  assign w_locked = (r_state == LOCKED);
  assign w_done   = w_locked & w_vld & m_TREADY & w_last;

  // Unregistered pass-through keeps full beat-per-cycle throughput inside a packet
  assign m_TVALID = w_locked & w_vld;
  assign m_TDATA  = w_locked ? w_data : '0;
  assign m_TKEEP  = w_locked ? w_keep : '0;
  assign m_TLAST  = w_locked & w_last;

  always_comb begin
    src_TREADY = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      src_TREADY[i] = w_locked && (r_grant == GW'(i)) && m_TREADY;
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= GW'(N_REQ - 1);
      r_busy      <= 1'b0;
      r_pkt_count <= '0;
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_stall_cnt <= '0;
          if (w_any) begin
            r_grant <= w_winner;
            r_busy  <= 1'b1;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          // Only an absent TVALID counts; backpressure is not a stall
          if (w_vld) begin
            r_stall_cnt <= '0;
          end else if (r_stall_cnt != SW'(STALL_LIMIT)) begin
            r_stall_cnt <= r_stall_cnt + SW'(1);
          end
          if (!w_vld && (r_stall_cnt == SW'(STALL_LIMIT - 1))) begin
            r_stall_err <= 1'b1;
          end
          if (w_done) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_rr_ptr    <= r_grant;
            r_pkt_count <= r_pkt_count + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign grant_id  = r_grant;
  assign pkt_count = r_pkt_count;
  assign stall_err = r_stall_err;

endmodule
